// File: rtl/voice_allocator_pkg.sv
// Shared types and default widths for the voice allocator.
package voice_allocator_pkg;

   localparam int DEF_NV     = 4;
   localparam int DEF_NOTE_W = 7;
   localparam int DEF_AGE_W  = 8;

   // Allocator control states.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SEARCH = 3'd1,
      ST_KILL   = 3'd2,
      ST_WAIT   = 3'd3,
      ST_ISSUE  = 3'd4
   } state_e;

endpackage

// File: rtl/voice_select.sv
// Combinational voice selection: held-note match, lowest free voice and
// oldest voice (max age, ties to the lowest index).
module voice_select
   import voice_allocator_pkg::*;
#(
   parameter int NV     = DEF_NV,
   parameter int NOTE_W = DEF_NOTE_W,
   parameter int AGE_W  = DEF_AGE_W,
   parameter int IDX_W  = $clog2(NV)
) (
   input  logic [NV-1:0]             held,
   input  logic [NV-1:0]             busy,
   input  logic [NV-1:0][NOTE_W-1:0] notes,
   input  logic [NV-1:0][AGE_W-1:0]  ages,
   input  logic [NOTE_W-1:0]         key,
   output logic                      match_found,
   output logic [IDX_W-1:0]          match_idx,
   output logic                      free_found,
   output logic [IDX_W-1:0]          free_idx,
   output logic [IDX_W-1:0]          oldest_idx
);

   logic [AGE_W-1:0] best_age;

   // Priority encoders; the descending scans leave the lowest index as winner.
   always_comb begin
      match_found = 1'b0;
      match_idx   = '0;
      free_found  = 1'b0;
      free_idx    = '0;
      oldest_idx  = '0;
      best_age    = ages[0];
      for (int i = NV - 1; i >= 0; i--) begin
         if (held[i] && (notes[i] == key)) begin
            match_found = 1'b1;
            match_idx   = IDX_W'(i);
         end
         if (!held[i] && !busy[i]) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
      end
      // Strict compare keeps the earlier (lower) index on equal ages.
      for (int i = 1; i < NV; i++) begin
         if (ages[i] > best_age) begin
            best_age   = ages[i];
            oldest_idx = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: maps key press/release commands onto NV
// envelope-generator voices, retriggering, using free voices or stealing
// the oldest one.
//
// Handshake: a command transfers on a rising clk edge where
// cmd_valid & cmd_ready are both 1; cmd_ready is high only while idle, and
// cmd_on/cmd_note are captured on that same edge.
module voice_allocator
   import voice_allocator_pkg::*;
#(
   parameter int NV     = DEF_NV,
   parameter int NOTE_W = DEF_NOTE_W,
   parameter int AGE_W  = DEF_AGE_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cmd_valid,
   input  logic                 cmd_on,
   input  logic [NOTE_W-1:0]    cmd_note,
   output logic                 cmd_ready,
   input  logic [NV-1:0]        voice_busy,
   output logic [NV-1:0]        note_on,
   output logic [NV-1:0]        note_off,
   output logic [NV*NOTE_W-1:0] voice_note,
   output logic [NV-1:0]        voice_held,
   output logic                 stolen,
   output logic [2:0]           dbg_state
);

   localparam int IDX_W = $clog2(NV);

   state_e                     state_q, state_d;
   logic                       on_q, on_d;
   logic [NOTE_W-1:0]          key_q, key_d;
   logic [IDX_W-1:0]           voice_q, voice_d;
   logic                       steal_q, steal_d;
   logic [NV-1:0]              held_q, held_d;
   logic [NV-1:0][NOTE_W-1:0]  note_q, note_d;
   logic [NV-1:0][AGE_W-1:0]   age_q, age_d;

   logic                       match_found, free_found;
   logic [IDX_W-1:0]           match_idx, free_idx, oldest_idx;

   voice_select #(
      .NV     (NV),
      .NOTE_W (NOTE_W),
      .AGE_W  (AGE_W),
      .IDX_W  (IDX_W)
   ) u_select (
      .held        (held_q),
      .busy        (voice_busy),
      .notes       (note_q),
      .ages        (age_q),
      .key         (key_q),
      .match_found (match_found),
      .match_idx   (match_idx),
      .free_found  (free_found),
      .free_idx    (free_idx),
      .oldest_idx  (oldest_idx)
   );

   // Next-state logic; held/note change on entry to KILL/ISSUE so they are
   // already visible while the matching pulse is out.
   always_comb begin
      state_d = state_q;
      on_d    = on_q;
      key_d   = key_q;
      voice_d = voice_q;
      steal_d = steal_q;
      held_d  = held_q;
      note_d  = note_q;
      age_d   = age_q;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               on_d    = cmd_on;
               key_d   = cmd_note;
               state_d = ST_SEARCH;
            end
         end
         ST_SEARCH: begin
            if (!on_q) begin
               if (match_found) begin
                  voice_d           = match_idx;
                  held_d[match_idx] = 1'b0;
                  state_d           = ST_KILL;
               end else begin
                  state_d = ST_IDLE;
               end
            end else if (match_found) begin
               voice_d           = match_idx;
               steal_d           = 1'b0;
               held_d[match_idx] = 1'b0;
               state_d           = ST_KILL;
            end else if (free_found) begin
               voice_d          = free_idx;
               steal_d          = 1'b0;
               held_d[free_idx] = 1'b1;
               note_d[free_idx] = key_q;
               state_d          = ST_ISSUE;
            end else begin
               voice_d            = oldest_idx;
               steal_d            = 1'b1;
               held_d[oldest_idx] = 1'b0;
               state_d            = ST_KILL;
            end
         end
         ST_KILL: begin
            // A release ends after its note_off; a press waits for the voice.
            state_d = on_q ? ST_WAIT : ST_IDLE;
         end
         ST_WAIT: begin
            if (!voice_busy[voice_q]) begin
               held_d[voice_q] = 1'b1;
               note_d[voice_q] = key_q;
               state_d         = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            for (int i = 0; i < NV; i++) begin
               if (IDX_W'(i) == voice_q) begin
                  age_d[i] = '0;
               end else if (held_q[i] && (age_q[i] != {AGE_W{1'b1}})) begin
                  age_d[i] = age_q[i] + AGE_W'(1);
               end
            end
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and voice bookkeeping registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         on_q    <= 1'b0;
         key_q   <= '0;
         voice_q <= '0;
         steal_q <= 1'b0;
         held_q  <= '0;
         note_q  <= '0;
         age_q   <= '0;
      end else begin
         state_q <= state_d;
         on_q    <= on_d;
         key_q   <= key_d;
         voice_q <= voice_d;
         steal_q <= steal_d;
         held_q  <= held_d;
         note_q  <= note_d;
         age_q   <= age_d;
      end
   end

   // Pulses decode purely from state, so a reset can never leave one pending.
   assign cmd_ready  = (state_q == ST_IDLE);
   assign note_on    = (state_q == ST_ISSUE) ? (NV'(1) << voice_q) : '0;
   assign note_off   = (state_q == ST_KILL)  ? (NV'(1) << voice_q) : '0;
   assign stolen     = (state_q == ST_ISSUE) && steal_q;
   assign voice_held = held_q;
   assign voice_note = note_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: directed table, hand-written
// reset-in-WAIT sequence, then randomized commands against a note/age model.
module tb_voice_allocator;

   localparam int NV     = 4;
   localparam int NOTE_W = 7;
   localparam int AGE_W  = 3;
   localparam int AMAX   = (1 << AGE_W) - 1;

   localparam int K_REL_NONE = 0;
   localparam int K_REL      = 1;
   localparam int K_FREE     = 2;
   localparam int K_RETRIG   = 3;
   localparam int K_STEAL    = 4;

   logic                 clk;
   logic                 rst;
   logic                 cmd_valid;
   logic                 cmd_on;
   logic [NOTE_W-1:0]    cmd_note;
   logic                 cmd_ready;
   logic [NV-1:0]        voice_busy;
   logic [NV-1:0]        note_on;
   logic [NV-1:0]        note_off;
   logic [NV*NOTE_W-1:0] voice_note;
   logic [NV-1:0]        voice_held;
   logic                 stolen;
   logic [2:0]           dbg_state;

   int n_vec;
   int n_bad;

   // Reference model: which voices are held, their notes and their ages.
   bit m_held[NV];
   int m_note[NV];
   int m_age[NV];

   typedef struct {
      bit            on;
      int            note;
      logic [NV-1:0] busy;
      int            wcyc;
      int            kind;
      int            v;
   } vec_t;

   vec_t tbl[12];

   voice_allocator #(
      .NV     (NV),
      .NOTE_W (NOTE_W),
      .AGE_W  (AGE_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_on     (cmd_on),
      .cmd_note   (cmd_note),
      .cmd_ready  (cmd_ready),
      .voice_busy (voice_busy),
      .note_on    (note_on),
      .note_off   (note_off),
      .voice_note (voice_note),
      .voice_held (voice_held),
      .stolen     (stolen),
      .dbg_state  (dbg_state)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_out(input string tag, input logic [NV-1:0] on_e, input logic [NV-1:0] off_e,
                          input logic st_e, input logic rdy_e);
      chk({tag, ".note_on"}, 32'(note_on), 32'(on_e));
      chk({tag, ".note_off"}, 32'(note_off), 32'(off_e));
      chk({tag, ".stolen"}, 32'(stolen), 32'(st_e));
      chk({tag, ".cmd_ready"}, 32'(cmd_ready), 32'(rdy_e));
   endtask

   task automatic chk_model(input string tag);
      logic [NV-1:0]        eh;
      logic [NV*NOTE_W-1:0] en;
      for (int i = 0; i < NV; i++) begin
         eh[i] = m_held[i];
         en[i*NOTE_W +: NOTE_W] = NOTE_W'(m_note[i]);
      end
      chk({tag, ".voice_held"}, 32'(voice_held), 32'(eh));
      chk({tag, ".voice_note"}, 32'(voice_note), 32'(en));
   endtask

   function automatic void model_reset();
      for (int i = 0; i < NV; i++) begin
         m_held[i] = 1'b0;
         m_note[i] = 0;
         m_age[i]  = 0;
      end
   endfunction

   // Voice choice straight from the allocation rules.
   function automatic void predict(input bit on, input int n, input logic [NV-1:0] busy,
                                   output int kind, output int v);
      int best;
      kind = -1;
      v    = 0;
      for (int i = 0; i < NV; i++)
         if (kind < 0 && m_held[i] && m_note[i] == n) begin
            kind = on ? K_RETRIG : K_REL;
            v    = i;
         end
      if (kind < 0 && !on) kind = K_REL_NONE;
      if (kind < 0)
         for (int i = 0; i < NV; i++)
            if (kind < 0 && !m_held[i] && !busy[i]) begin
               kind = K_FREE;
               v    = i;
            end
      if (kind < 0) begin
         kind = K_STEAL;
         best = -1;
         for (int i = 0; i < NV; i++)
            if (m_age[i] > best) begin
               best = m_age[i];
               v    = i;
            end
      end
   endfunction

   function automatic void model_issue(input int v, input int n);
      for (int i = 0; i < NV; i++)
         if (i != v && m_held[i] && m_age[i] < AMAX) m_age[i]++;
      m_age[v]  = 0;
      m_held[v] = 1'b1;
      m_note[v] = n;
   endfunction

   // Drive one command and check every cycle until the allocator is idle again.
   task automatic run_cmd(input string tag, input bit on, input int n, input logic [NV-1:0] busy,
                          input int wcyc, input int kind, input int v);
      logic [NV-1:0] oh;
      oh = NV'(1) << v;
      @(negedge clk);
      voice_busy = busy;
      cmd_on     = on;
      cmd_note   = NOTE_W'(n);
      cmd_valid  = 1'b1;
      chk({tag, ".ready_at_req"}, 32'(cmd_ready), 32'd1);
      @(negedge clk);
      cmd_valid = 1'b0;
      chk_out({tag, ".search"}, '0, '0, 1'b0, 1'b0);
      if (kind == K_REL) begin
         @(negedge clk);
         chk_out({tag, ".kill"}, '0, oh, 1'b0, 1'b0);
         m_held[v] = 1'b0;
      end else if (kind == K_FREE) begin
         @(negedge clk);
         chk_out({tag, ".issue"}, oh, '0, 1'b0, 1'b0);
         chk({tag, ".issue_note"}, 32'(voice_note[v*NOTE_W +: NOTE_W]), 32'(n));
         model_issue(v, n);
      end else if (kind == K_RETRIG || kind == K_STEAL) begin
         @(negedge clk);
         chk_out({tag, ".kill"}, '0, oh, 1'b0, 1'b0);
         m_held[v]     = 1'b0;
         voice_busy[v] = 1'b1;
         for (int c = 0; c < wcyc; c++) begin
            @(negedge clk);
            chk_out({tag, ".wait"}, '0, '0, 1'b0, 1'b0);
         end
         @(negedge clk);
         chk_out({tag, ".wait_last"}, '0, '0, 1'b0, 1'b0);
         voice_busy[v] = 1'b0;
         @(negedge clk);
         chk_out({tag, ".issue"}, oh, '0, kind == K_STEAL, 1'b0);
         chk({tag, ".issue_note"}, 32'(voice_note[v*NOTE_W +: NOTE_W]), 32'(n));
         model_issue(v, n);
      end
      @(negedge clk);
      chk_out({tag, ".done"}, '0, '0, 1'b0, 1'b1);
      chk_model(tag);
   endtask

   initial begin
      int kind;
      int v;
      int n;
      bit on;
      logic [NV-1:0] busy;
      logic [NV-1:0] oh;

      n_vec = 0;
      n_bad = 0;
      model_reset();

      // Directed table: {on, note, busy, wait cycles, expected path, expected voice}.
      tbl[0]  = '{1'b1, 60, 4'b0000, 0, K_FREE,     0};
      tbl[1]  = '{1'b1, 62, 4'b0000, 0, K_FREE,     1};
      tbl[2]  = '{1'b1, 64, 4'b0000, 0, K_FREE,     2};
      tbl[3]  = '{1'b1, 65, 4'b0000, 0, K_FREE,     3};
      tbl[4]  = '{1'b0, 62, 4'b0000, 0, K_REL,      1};
      tbl[5]  = '{1'b0, 70, 4'b0000, 0, K_REL_NONE, 0};
      tbl[6]  = '{1'b1, 62, 4'b0000, 0, K_FREE,     1};
      tbl[7]  = '{1'b1, 67, 4'b1111, 9, K_STEAL,    0};
      tbl[8]  = '{1'b1, 67, 4'b0000, 2, K_RETRIG,   0};
      tbl[9]  = '{1'b1, 50, 4'b1111, 0, K_STEAL,    2};
      tbl[10] = '{1'b0, 67, 4'b0000, 0, K_REL,      0};
      tbl[11] = '{1'b1, 61, 4'b0001, 1, K_STEAL,    3};

      // Reset
      rst        = 1'b1;
      cmd_valid  = 1'b0;
      cmd_on     = 1'b0;
      cmd_note   = '0;
      voice_busy = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk_out("reset", '0, '0, 1'b0, 1'b1);
      chk_model("reset");

      for (int t = 0; t < 12; t++)
         run_cmd($sformatf("tbl%0d", t), tbl[t].on, tbl[t].note, tbl[t].busy,
                 tbl[t].wcyc, tbl[t].kind, tbl[t].v);

      // Reset while parked in WAIT: nothing may be issued afterwards.
      predict(1'b1, 90, 4'b1111, kind, v);
      oh = NV'(1) << v;
      @(negedge clk);
      voice_busy = 4'b1111;
      cmd_on     = 1'b1;
      cmd_note   = NOTE_W'(90);
      cmd_valid  = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      chk_out("rstwait.kill", '0, oh, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      chk_out("rstwait.wait", '0, '0, 1'b0, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      rst        = 1'b0;
      voice_busy = '0;
      model_reset();
      chk_out("rstwait.after", '0, '0, 1'b0, 1'b1);
      chk_model("rstwait.after");
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk_out("rstwait.quiet", '0, '0, 1'b0, 1'b1);
      end
      chk_model("rstwait.quiet");

      // Randomized commands over a narrow note range to force matches/steals.
      for (int r = 0; r < 150; r++) begin
         on   = ($urandom_range(0, 2) != 0);
         n    = 60 + $urandom_range(0, 3);
         busy = NV'($urandom_range(0, (1 << NV) - 1));
         predict(on, n, busy, kind, v);
         run_cmd($sformatf("rnd%0d", r), on, n, busy, $urandom_range(0, 3), kind, v);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
